// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of the cpu32 core.
//
// Contents of this file:
//   alu_pkg   : ALU operation codes and flag bit positions shared by the ALU,
//               the execute stage and anything that decodes out_flags.
//   alu_core  : purely combinational ALU (add/sub/logic/shift/compare).
//   ex_stage  : operand forwarding, one alu_core instance, and the EX/MEM
//               output register with its own valid/ready handshake.
//
// ex_stage ports:
//   clk, rst          : clock, synchronous active-high reset
//   flush             : drop the in-flight instruction (branch redirect)
//   in_valid/in_ready : handshake from decode
//   in_rs1/in_rs2     : source register indices
//   in_rs1_val/_rs2_val : register-file read data for the sources
//   in_imm/in_use_imm : sign-extended immediate and operand-B select
//   in_alu_op         : ALU operation (alu_pkg::alu_op_e encoding)
//   in_rd/in_rd_we    : destination index and write enable
//   fwd_mem_*         : bypass from the MEM stage (highest priority)
//   fwd_wb_*          : bypass from the WB stage
//   out_valid/out_ready : handshake toward the MEM stage
//   out_result/out_flags/out_rd/out_rd_we : registered EX/MEM payload
//   busy_cnt          : saturating count of cycles stalled by MEM
// ---------------------------------------------------------------------------

package alu_pkg;

    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_AND  = 4'd2,
        ALU_OP_OR   = 4'd3,
        ALU_OP_XOR  = 4'd4,
        ALU_OP_SLL  = 4'd5,
        ALU_OP_SRL  = 4'd6,
        ALU_OP_SRA  = 4'd7,
        ALU_OP_SLT  = 4'd8,
        ALU_OP_SLTU = 4'd9
    } alu_op_e;

    // Bit positions inside the 4-bit FLAGS vector.
    localparam int ALU_FLAG_Z = 0;
    localparam int ALU_FLAG_N = 1;
    localparam int ALU_FLAG_C = 2;
    localparam int ALU_FLAG_V = 3;

endpackage

// ---------------------------------------------------------------------------
// alu_core -- combinational ALU.
//   i_a, i_b : operands
//   i_op     : operation code (alu_op_e); unknown codes give Y=0
//   o_y      : result
//   o_flags  : Z/N from the result; C/V from the adder for ADD/SUB only,
//              0 for every other operation. For SUB, C is the inverted
//              borrow (1 when i_a >= i_b unsigned).
// ---------------------------------------------------------------------------
module alu_core #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [3:0]      i_op,
    output logic [XLEN-1:0] o_y,
    output logic [3:0]      o_flags
);
    import alu_pkg::*;

    localparam int SHW = $clog2(XLEN);

    logic            w_sub;
    logic [XLEN-1:0] w_b_eff;
    logic [XLEN:0]   w_sum;
    logic            w_ovf;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_y;
    logic            w_c;
    logic            w_v;

    // One shared adder: subtraction is A + ~B + 1.
    assign w_sub   = (i_op == ALU_OP_SUB);
    assign w_b_eff = w_sub ? ~i_b : i_b;
    assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{XLEN{1'b0}}, w_sub};

    // Signed overflow: both addends share a sign that the sum does not.
    assign w_ovf   = (i_a[XLEN-1] == w_b_eff[XLEN-1]) &&
                     (w_sum[XLEN-1] != i_a[XLEN-1]);

    assign w_shamt = i_b[SHW-1:0];

    always_comb begin
        // NOTE: every always_comb output gets a default before the case so
        // that no path leaves it unassigned and no latch is inferred.
        w_y = '0;
        w_c = 1'b0;
        w_v = 1'b0;
        case (i_op)
            ALU_OP_ADD,
            ALU_OP_SUB: begin
                w_y = w_sum[XLEN-1:0];
                w_c = w_sum[XLEN];
                w_v = w_ovf;
            end
            ALU_OP_AND:  w_y = i_a & i_b;
            ALU_OP_OR:   w_y = i_a | i_b;
            ALU_OP_XOR:  w_y = i_a ^ i_b;
            ALU_OP_SLL:  w_y = i_a << w_shamt;
            ALU_OP_SRL:  w_y = i_a >> w_shamt;
            ALU_OP_SRA:  w_y = XLEN'($signed(i_a) >>> w_shamt);
            ALU_OP_SLT:  w_y = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_OP_SLTU: w_y = {{(XLEN-1){1'b0}}, (i_a < i_b)};
            default:     w_y = '0;
        endcase
    end

    always_comb begin
        o_flags             = '0;
        o_flags[ALU_FLAG_Z] = (w_y == '0);
        o_flags[ALU_FLAG_N] = w_y[XLEN-1];
        o_flags[ALU_FLAG_C] = w_c;
        o_flags[ALU_FLAG_V] = w_v;
    end

    assign o_y = w_y;

endmodule

// ---------------------------------------------------------------------------
// ex_stage -- execute stage top (see file header for port summary).
// ---------------------------------------------------------------------------
module ex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [REGW-1:0] in_rs1,
    input  logic [REGW-1:0] in_rs2,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic [3:0]      in_alu_op,
    input  logic [REGW-1:0] in_rd,
    input  logic            in_rd_we,

    input  logic            fwd_mem_we,
    input  logic [REGW-1:0] fwd_mem_rd,
    input  logic [XLEN-1:0] fwd_mem_data,
    input  logic            fwd_wb_we,
    input  logic [REGW-1:0] fwd_wb_rd,
    input  logic [XLEN-1:0] fwd_wb_data,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [3:0]      out_flags,
    output logic [REGW-1:0] out_rd,
    output logic            out_rd_we,
    output logic [15:0]     busy_cnt
);

    // Forwarded operands and ALU connections.
    logic [XLEN-1:0] w_fwd_a;
    logic [XLEN-1:0] w_fwd_b;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_alu_y;
    logic [3:0]      w_alu_flags;
    logic            w_accept;

    // EX/MEM output register.
    logic            r_out_valid;
    logic [XLEN-1:0] r_out_result;
    logic [3:0]      r_out_flags;
    logic [REGW-1:0] r_out_rd;
    logic            r_out_rd_we;
    logic [15:0]     r_busy_cnt;

    // -----------------------------------------------------------------------
    // Operand forwarding. MEM holds the younger result, so it wins over WB.
    // Register 0 reads as the register-file value (hard-wired zero) even if
    // a later stage claims to write it.
    // -----------------------------------------------------------------------
    always_comb begin
        w_fwd_a = in_rs1_val;
        if (in_rs1 != '0) begin
            if (fwd_mem_we && (fwd_mem_rd == in_rs1)) begin
                w_fwd_a = fwd_mem_data;
            end else if (fwd_wb_we && (fwd_wb_rd == in_rs1)) begin
                w_fwd_a = fwd_wb_data;
            end
        end
    end

    always_comb begin
        w_fwd_b = in_rs2_val;
        if (in_rs2 != '0) begin
            if (fwd_mem_we && (fwd_mem_rd == in_rs2)) begin
                w_fwd_b = fwd_mem_data;
            end else if (fwd_wb_we && (fwd_wb_rd == in_rs2)) begin
                w_fwd_b = fwd_wb_data;
            end
        end
    end

    assign w_op_a = w_fwd_a;
    assign w_op_b = in_use_imm ? in_imm : w_fwd_b;

    alu_core #(
        .XLEN (XLEN)
    ) u_alu (
        .i_a     (w_op_a),
        .i_b     (w_op_b),
        .i_op    (in_alu_op),
        .o_y     (w_alu_y),
        .o_flags (w_alu_flags)
    );

    // -----------------------------------------------------------------------
    // Handshake. The register can take a new instruction when it is empty or
    // is being drained this cycle. in_ready is deliberately independent of
    // in_valid and flush to avoid a combinational loop through decode.
    // -----------------------------------------------------------------------
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready && !flush;

    // -----------------------------------------------------------------------
    // EX/MEM register. Flush only clears valid; the payload keeps its last
    // value because nothing downstream looks at it while valid is low.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: reset is synchronous; the payload registers are reset too
            // so out_* read as zero right after reset, not just out_valid.
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_flags  <= '0;
            r_out_rd     <= '0;
            r_out_rd_we  <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_result <= w_alu_y;
            r_out_flags  <= w_alu_flags;
            r_out_rd     <= in_rd;
            r_out_rd_we  <= in_rd_we;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    // Stall counter for debug: counts cycles where MEM refuses a valid
    // result, sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy_cnt <= '0;
        end else if (r_out_valid && !out_ready && (r_busy_cnt != 16'hFFFF)) begin
            r_busy_cnt <= r_busy_cnt + 16'd1;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_flags  = r_out_flags;
    assign out_rd     = r_out_rd;
    assign out_rd_we  = r_out_rd_we;
    assign busy_cnt   = r_busy_cnt;

endmodule
